// File: rtl/ps2_mouse_decoder.sv
// PS/2 mouse receiver and cursor tracker.
// Receives 11-bit PS/2 frames (start, 8 data LSB first, odd parity, stop)
// and assembles 3-byte movement packets. Each packet moves a cursor clamped
// to [0,H_MAX] x [0,V_MAX], with Y growing downward, and latches the button state.
//
// Optional build macro: PS2_PARITY_CHK_EN. When it is defined, frames with
// bad odd parity are dropped. When it is undefined, the parity bit is ignored.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   ps2_clk       raw PS/2 clock (input only)
//   ps2_data      raw PS/2 data
//   mouse_x       cursor X, 0..H_MAX
//   mouse_y       cursor Y, 0..V_MAX (top = 0)
//   mouse_click   {5'b0, middle, right, left}
//   packet_valid  one-cycle pulse when a packet is applied
//   frame_err     one-cycle pulse when a frame is discarded
//
// Frame FSM
//   state  | meaning
//   F_IDLE | waiting for a start bit (falling edge with data 0)
//   F_RECV | shifting data, parity and stop bits; idle timeout armed
//   F_DONE | one cycle to judge the completed frame
// Packet FSM
//   state   | meaning
//   P_BYTE0 | expecting the status byte (bit3 must be 1)
//   P_BYTE1 | expecting the X movement byte
//   P_BYTE2 | expecting the Y movement byte; apply on acceptance
module ps2_mouse_decoder #(
   parameter int H_MAX       = 639,
   parameter int V_MAX       = 479,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [15:0] mouse_x,
   output logic [15:0] mouse_y,
   output logic [7:0]  mouse_click,
   output logic        packet_valid,
   output logic        frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {F_IDLE, F_RECV, F_DONE} frame_t;
   typedef enum logic [1:0] {P_BYTE0, P_BYTE1, P_BYTE2} pkt_t;

   frame_t frame_q, frame_nxt;
   pkt_t   pkt_q, pkt_nxt;

   logic          clk_s1, clk_s2, clk_d, dat_s1, dat_s2;
   logic          fall;
   logic [3:0]    bit_cnt;
   logic [7:0]    shift_q;
   logic          stop_q;
   logic [TW-1:0] tmr;
   logic          par_ok, byte_ok, frame_bad, apply;

   // Status byte fields kept from byte 0; bit3 only gates acceptance.
   logic          ovf_y, ovf_x, sgn_y, sgn_x;
   logic [2:0]    btn_q;
   logic [7:0]    b1_q;

   logic signed [8:0]  dx, dy;
   logic signed [17:0] nx, ny;
   logic [15:0]        cx, cy;

   assign fall = clk_d & ~clk_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         clk_d  <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         clk_d  <= clk_s2;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
      end
   end

`ifdef PS2_PARITY_CHK_EN
   logic par_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         par_q <= 1'b0;
      else if (frame_q == F_RECV && fall && bit_cnt == 4'd8)
         par_q <= dat_s2;
   end
   assign par_ok = ^{shift_q, par_q};
`else
   assign par_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= '0;
         shift_q <= '0;
         stop_q  <= 1'b0;
         tmr     <= '0;
      end else begin
         if (frame_q == F_IDLE && fall && !dat_s2) begin
            bit_cnt <= '0;
            tmr     <= TMR_LOAD;
         end
         if (frame_q == F_RECV) begin
            if (fall) begin
               tmr     <= TMR_LOAD;
               bit_cnt <= bit_cnt + 4'd1;
               if (bit_cnt < 4'd8)
                  shift_q <= {dat_s2, shift_q[7:1]};
               else if (bit_cnt == 4'd9)
                  stop_q <= dat_s2;
            end else if (tmr != '0) begin
               tmr <= tmr - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_q <= F_IDLE;
         pkt_q   <= P_BYTE0;
      end else begin
         frame_q <= frame_nxt;
         pkt_q   <= pkt_nxt;
      end
   end

   always_comb begin
      frame_nxt = frame_q;
      byte_ok   = 1'b0;
      frame_bad = 1'b0;
      case (frame_q)
         F_IDLE: if (fall && !dat_s2) frame_nxt = F_RECV;
         F_RECV: begin
            if (fall && bit_cnt == 4'd9) begin
               frame_nxt = F_DONE;
            end else if (!fall && tmr == '0) begin
               frame_nxt = F_IDLE;
               frame_bad = 1'b1;
            end
         end
         F_DONE: begin
            frame_nxt = F_IDLE;
            if (stop_q && par_ok) byte_ok   = 1'b1;
            else                  frame_bad = 1'b1;
         end
         default: frame_nxt = F_IDLE;
      endcase
   end

   always_comb begin
      pkt_nxt = pkt_q;
      apply   = 1'b0;
      if (frame_bad) begin
         pkt_nxt = P_BYTE0;
      end else if (byte_ok) begin
         case (pkt_q)
            P_BYTE0: if (shift_q[3]) pkt_nxt = P_BYTE1;
            P_BYTE1: pkt_nxt = P_BYTE2;
            P_BYTE2: begin
               pkt_nxt = P_BYTE0;
               apply   = 1'b1;
            end
            default: pkt_nxt = P_BYTE0;
         endcase
      end
   end

   // Byte 2 is still sitting in shift_q while apply is high.
   always_comb begin
      dx = ovf_x ? 9'sd0 : $signed({sgn_x, b1_q});
      dy = ovf_y ? 9'sd0 : $signed({sgn_y, shift_q});
      nx = $signed({2'b00, mouse_x}) + $signed({{9{dx[8]}}, dx});
      ny = $signed({2'b00, mouse_y}) - $signed({{9{dy[8]}}, dy});
      if (nx < 0)          cx = 16'd0;
      else if (nx > H_MAX) cx = 16'(H_MAX);
      else                 cx = nx[15:0];
      if (ny < 0)          cy = 16'd0;
      else if (ny > V_MAX) cy = 16'(V_MAX);
      else                 cy = ny[15:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_y        <= 1'b0;
         ovf_x        <= 1'b0;
         sgn_y        <= 1'b0;
         sgn_x        <= 1'b0;
         btn_q        <= '0;
         b1_q         <= '0;
         mouse_x      <= 16'((H_MAX + 1) / 2);
         mouse_y      <= 16'((V_MAX + 1) / 2);
         mouse_click  <= '0;
         packet_valid <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         packet_valid <= apply;
         frame_err    <= frame_bad;
         if (byte_ok && pkt_q == P_BYTE0 && shift_q[3]) begin
            ovf_y <= shift_q[7];
            ovf_x <= shift_q[6];
            sgn_y <= shift_q[5];
            sgn_x <= shift_q[4];
            btn_q <= shift_q[2:0];
         end
         if (byte_ok && pkt_q == P_BYTE1)
            b1_q <= shift_q;
         if (apply) begin
            mouse_x     <= cx;
            mouse_y     <= cy;
            mouse_click <= {5'b0, btn_q};
         end
      end
   end

endmodule

// File: tb/tb_ps2_mouse_decoder.sv
module tb_ps2_mouse_decoder;

   localparam int TMO  = 1000;
   localparam int HALF = 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [15:0] mouse_x, mouse_y;
   logic [7:0]  mouse_click;
   logic        packet_valid, frame_err;

   ps2_mouse_decoder #(.H_MAX(639), .V_MAX(479), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_click(mouse_click),
      .packet_valid(packet_valid), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_pkt;
      logic [15:0] x;
      logic [15:0] y;
      logic [7:0]  c;
   } exp_t;

   exp_t sb[$];
   int   tests_run = 0;
   int   tests_failed = 0;
   int   cyc = 0;
   int   stop_cyc = 0;
   int   mx, my;
   logic [7:0] mc;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: every output pulse must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && (packet_valid || frame_err)) begin
            tests_run++;
            if (packet_valid && frame_err) begin
               tests_failed++;
               $display("FAIL both_pulses: packet_valid=1 frame_err=1 required not both");
            end else if (sb.size() == 0) begin
               tests_failed++;
               $display("FAIL unexpected_pulse: packet_valid=%0b frame_err=%0b required none", packet_valid, frame_err);
            end else begin
               e = sb.pop_front();
               if (packet_valid !== e.is_pkt) begin
                  tests_failed++;
                  $display("FAIL event_kind: packet_valid=%0b required %0b", packet_valid, e.is_pkt);
               end else if (e.is_pkt) begin
                  if (mouse_x !== e.x || mouse_y !== e.y || mouse_click !== e.c) begin
                     tests_failed++;
                     $display("FAIL packet_out: got x=%0d y=%0d c=%h required x=%0d y=%0d c=%h",
                              mouse_x, mouse_y, mouse_click, e.x, e.y, e.c);
                  end
                  tests_run++;
                  if (cyc - stop_cyc !== 4) begin
                     tests_failed++;
                     $display("FAIL latency: got %0d cycles after stop drive, required 4", cyc - stop_cyc);
                  end
               end
            end
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      mx = 320; my = 240; mc = 8'h00;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      wait_cyc(3);
      rst_n = 1'b1;
      model_reset();
      wait_cyc(3);
   endtask

   task automatic send_bits(input logic [7:0] d, input bit bad_par, input int nbits);
      logic [10:0] fr;
      logic        p;
      p  = bad_par ? (^d) : ~(^d);
      fr = {1'b1, p, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         ps2_data = fr[i];
         wait_cyc(HALF);
         ps2_clk = 1'b0;
         if (i == 10) stop_cyc = cyc;
         wait_cyc(HALF);
         ps2_clk = 1'b1;
      end
      wait_cyc(HALF);
   endtask

   task automatic send_byte(input logic [7:0] d);
      send_bits(d, 1'b0, 11);
   endtask

   task automatic push_err();
      exp_t e;
      e.is_pkt = 1'b0; e.x = '0; e.y = '0; e.c = '0;
      sb.push_back(e);
   endtask

   task automatic model_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      int dx, dy;
      exp_t e;
      dx = (b0[4] ? -256 : 0) + int'(b1);
      dy = (b0[5] ? -256 : 0) + int'(b2);
      if (b0[6]) dx = 0;
      if (b0[7]) dy = 0;
      mx = mx + dx;
      my = my - dy;
      if (mx < 0) mx = 0;
      if (mx > 639) mx = 639;
      if (my < 0) my = 0;
      if (my > 479) my = 479;
      mc = {5'b0, b0[2:0]};
      e.is_pkt = 1'b1; e.x = 16'(mx); e.y = 16'(my); e.c = mc;
      sb.push_back(e);
   endtask

   task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      model_pkt(b0, b1, b2);
      send_byte(b0);
      send_byte(b1);
      send_byte(b2);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         wait_cyc(1);
         n++;
      end
      tests_run++;
      if (sb.size() != 0) begin
         tests_failed++;
         $display("FAIL %s_drain: %0d expected events outstanding, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic check_out(input string name, input int ex, input int ey, input logic [7:0] ec);
      tests_run++;
      if (mouse_x !== 16'(ex) || mouse_y !== 16'(ey) || mouse_click !== ec) begin
         tests_failed++;
         $display("FAIL %s: got x=%0d y=%0d c=%h required x=%0d y=%0d c=%h",
                  name, mouse_x, mouse_y, mouse_click, ex, ey, ec);
      end
   endtask

   task automatic test_reset();
      do_reset();
      check_out("reset_out", 320, 240, 8'h00);
      tests_run++;
      if (packet_valid !== 1'b0 || frame_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_pulses: pv=%0b fe=%0b required 0 0", packet_valid, frame_err);
      end
   endtask

   task automatic test_basic();
      do_reset();
      send_pkt(8'h08, 8'h0A, 8'h05);
      drain("basic");
      check_out("basic_out", 330, 235, 8'h00);
   endtask

   task automatic test_clamp();
      do_reset();
      repeat (2) send_pkt(8'h19, 8'h00, 8'h00);
      drain("clamp_x");
      check_out("clamp_x_out", 0, 240, 8'h01);
      // Y sign bit set: dy = -128, cursor moves down toward V_MAX.
      repeat (3) send_pkt(8'h28, 8'h00, 8'h80);
      drain("clamp_y");
      check_out("clamp_y_out", 0, 479, 8'h00);
   endtask

   task automatic test_resync();
      do_reset();
      send_byte(8'h00);
      send_pkt(8'h09, 8'h00, 8'h00);
      drain("resync");
      check_out("resync_out", 320, 240, 8'h01);
   endtask

   task automatic test_parity();
      do_reset();
`ifdef PS2_PARITY_CHK_EN
      push_err();
      send_bits(8'h08, 1'b1, 11);
      drain("parity");
      check_out("parity_out", 320, 240, 8'h00);
`else
      model_pkt(8'h08, 8'h03, 8'h02);
      send_bits(8'h08, 1'b1, 11);
      send_byte(8'h03);
      send_byte(8'h02);
      drain("parity");
      check_out("parity_out", 323, 238, 8'h00);
`endif
   endtask

   task automatic test_timeout();
      do_reset();
      push_err();
      send_bits(8'h55, 1'b0, 5);
      wait_cyc(TMO + 50);
      drain("timeout");
      send_pkt(8'h0A, 8'h01, 8'h00);
      drain("timeout_next");
      check_out("timeout_out", 321, 240, 8'h02);
   endtask

   task automatic test_reset_mid();
      do_reset();
      send_pkt(8'h09, 8'h05, 8'h05);
      drain("mid_pre");
      send_byte(8'h08);
      send_byte(8'h20);
      do_reset();
      check_out("mid_reset_out", 320, 240, 8'h00);
      send_byte(8'h03);
      wait_cyc(20);
      drain("mid_none");
      send_pkt(8'h08, 8'h02, 8'h00);
      drain("mid_next");
      check_out("mid_next_out", 322, 240, 8'h00);
   endtask

   task automatic test_back_to_back();
      do_reset();
      send_pkt(8'h38, 8'hF6, 8'hFB);
      send_pkt(8'h4C, 8'h50, 8'h03);
      drain("b2b");
      check_out("b2b_out", 310, 242, 8'h04);
      wait_cyc(50);
      check_out("b2b_hold", 310, 242, 8'h04);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_clamp();
      test_resync();
      test_parity();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
